// File: rtl/integral_image_generator.sv
// integral_image_generator: streams a raster window of pixels into its integral image.
// Optional build macro II_SATURATE_EN clamps every addition at 2^II_WIDTH-1 instead of wrapping.
`default_nettype none

module integral_image_generator #(
   parameter int DATA_WIDTH = 8,
   parameter int IWIDTH     = 24,
   parameter int IHEIGHT    = 24,
   parameter int II_WIDTH   = 18
) (
   input  logic                       clk_fpga,
   input  logic                       reset_fpga,
   input  logic                       frame_start,
   input  logic [DATA_WIDTH-1:0]      pixel_in,
   input  logic                       pixel_valid,
   output logic                       pixel_ready,
   output logic [II_WIDTH-1:0]        ii_out,
   output logic [$clog2(IWIDTH)-1:0]  ii_x,
   output logic [$clog2(IHEIGHT)-1:0] ii_y,
   output logic                       ii_valid,
   input  logic                       ii_ready,
   output logic                       frame_done,
   output logic                       busy
);

   localparam int XW = $clog2(IWIDTH);
   localparam int YW = $clog2(IHEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IWIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IHEIGHT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

   state_t                state, state_next;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [II_WIDTH-1:0]   row_sum;
   logic [II_WIDTH-1:0]   line_buf [IWIDTH];
   logic [II_WIDTH-1:0]   row_base, above, row_sum_new, ii_new;
   logic                  accept;

   function automatic logic [II_WIDTH-1:0] add_ii(input logic [II_WIDTH-1:0] a,
                                                  input logic [II_WIDTH-1:0] b);
`ifdef II_SATURATE_EN
      logic [II_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      add_ii = s[II_WIDTH] ? {II_WIDTH{1'b1}} : s[II_WIDTH-1:0];
`else
      add_ii = a + b;
`endif
   endfunction

   // Row and column borders contribute zero rather than stale accumulator contents.
   always_comb begin
      row_base    = (x == '0) ? '0 : row_sum;
      above       = (y == '0) ? '0 : line_buf[x];
      row_sum_new = add_ii(row_base, {{(II_WIDTH-DATA_WIDTH){1'b0}}, pixel_in});
      ii_new      = add_ii(row_sum_new, above);
   end

   always_comb begin
      state_next  = state;
      pixel_ready = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) state_next = ACTIVE;
         end
         ACTIVE: begin
            pixel_ready = !ii_valid || ii_ready;
            accept      = pixel_valid && pixel_ready;
            if (accept && x == X_LAST && y == Y_LAST) state_next = FLUSH;
         end
         FLUSH: begin
            if (ii_valid && ii_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         row_sum    <= '0;
         ii_out     <= '0;
         ii_x       <= '0;
         ii_y       <= '0;
         ii_valid   <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < IWIDTH; i++) line_buf[i] <= '0;
      end else begin
         state      <= state_next;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  x       <= '0;
                  y       <= '0;
                  row_sum <= '0;
                  for (int i = 0; i < IWIDTH; i++) line_buf[i] <= '0;
               end
            end
            ACTIVE: begin
               if (accept) begin
                  row_sum     <= row_sum_new;
                  line_buf[x] <= ii_new;
                  ii_out      <= ii_new;
                  ii_x        <= x;
                  ii_y        <= y;
                  ii_valid    <= 1'b1;
                  if (x == X_LAST) begin
                     x <= '0;
                     y <= y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
               end else if (ii_ready) begin
                  ii_valid <= 1'b0;
               end
            end
            FLUSH: begin
               // Registered so the pulse lands the cycle after the final handshake.
               if (ii_valid && ii_ready) begin
                  ii_valid   <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_integral_image_generator.sv
// Scoreboard bench for integral_image_generator: a 2-D image model feeds expected sums to a monitor.
`default_nettype none

module tb_integral_image_generator;

   logic       clk_fpga = 1'b0, reset_fpga = 1'b0, frame_start = 1'b0;
   logic       pixel_valid = 1'b0, ii_ready = 1'b0;
   logic [7:0] pixel_in = '0;
   logic        pixel_ready, ii_valid, frame_done, busy;
   logic [17:0] ii_out;
   logic [4:0]  ii_x, ii_y;
   logic        pr16, iv16, fd16, busy16;
   logic [15:0] ii_out16;
   logic [4:0]  ix16, iy16;

   integral_image_generator dut (
      .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .frame_start(frame_start),
      .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .ii_out(ii_out), .ii_x(ii_x), .ii_y(ii_y), .ii_valid(ii_valid),
      .ii_ready(ii_ready), .frame_done(frame_done), .busy(busy));

   integral_image_generator #(.II_WIDTH(16)) dut16 (
      .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .frame_start(frame_start),
      .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pr16),
      .ii_out(ii_out16), .ii_x(ix16), .ii_y(iy16), .ii_valid(iv16),
      .ii_ready(ii_ready), .frame_done(fd16), .busy(busy16));

   always #5 clk_fpga = ~clk_fpga;

   typedef struct {longint sum; int x; int y; bit last;} exp_t;
   exp_t sb[$];

   int tests = 0, fails = 0;
   int img[576];
   int ready_mode = 0, stall_left = 0, done_cnt = 0, expect_done = 0;
   bit stall_en = 0, stall_done = 0, hold_pending = 0;
   logic [17:0] stall_val;
   logic [28:0] hold_val;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Integral value as the DUT should present it in a w-bit register.
   function automatic longint fit(input longint s, input int w);
      longint m = longint'(1) << w;
`ifdef II_SATURATE_EN
      return (s >= m) ? m - 1 : s;
`else
      return s % m;
`endif
   endfunction

   function automatic longint ref_ii(input int px, input int py);
      longint s = 0;
      for (int j = 0; j <= py; j++)
         for (int i = 0; i <= px; i++) s += img[j*24 + i];
      return s;
   endfunction

   // Monitor: drives ii_ready, pops the scoreboard on every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_fpga);
         if (stall_left > 0) ii_ready = 1'b0;
         else if (stall_en && !stall_done && ii_valid && ii_x == 5'd10 && ii_y == 5'd3) begin
            stall_left = 5; stall_done = 1; stall_val = ii_out; ii_ready = 1'b0;
         end else ii_ready = ready_mode ? 1'($urandom % 2) : 1'b1;
         #4;
         if (!reset_fpga) begin
            hold_pending = 0; stall_left = 0; expect_done = 0;
         end else begin
            if (stall_left > 0) begin
               check("stall_pixel_ready", pixel_ready, 0);
               check("stall_ii_hold", ii_out, stall_val);
               stall_left--;
            end
            if (hold_pending) check("hold_stable", {ii_valid, ii_x, ii_y, ii_out}, hold_val);
            hold_pending = ii_valid && !ii_ready;
            hold_val     = {ii_valid, ii_x, ii_y, ii_out};
            if (expect_done == 1) begin
               check("frame_done_pulse", frame_done, 1);
               check("frame_done_no_valid", ii_valid, 0);
               expect_done = 2; done_cnt++;
            end else if (expect_done == 2) begin
               check("frame_done_width", frame_done, 0);
               expect_done = 0;
            end else if (frame_done) check("frame_done_spurious", frame_done, 0);
            if (ii_valid && ii_ready) begin
               if (sb.size() == 0) check("scoreboard_underflow", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("ii_out", ii_out, fit(e.sum, 18));
                  check("ii_x", ii_x, e.x);
                  check("ii_y", ii_y, e.y);
                  check("ii_out_w16", ii_out16, fit(e.sum, 16));
                  check("ii_valid_w16", iv16, 1);
                  if (e.last) expect_done = 1;
               end
            end
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_pixel_ready", pixel_ready, 0);
      check("rst_ii_valid", ii_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_ii_out", ii_out, 0);
      check("rst_ii_x", ii_x, 0);
      check("rst_ii_y", ii_y, 0);
   endtask

   // kind: 0 = all ones, 1 = all 255, 2 = random. fs_at/rst_at: pixel index or -1.
   task automatic run_frame(input int kind, input bit rnd_valid, input int fs_at, input int rst_at);
      int idx = 0, c = 0, c2 = 0, d0;
      bit fs_done = 0;
      exp_t e;
      for (int i = 0; i < 576; i++)
         img[i] = (kind == 0) ? 1 : (kind == 1) ? 255 : int'($urandom_range(0, 255));
      while (idx < 576 && c < 5000) begin
         @(negedge clk_fpga);
         if (idx == rst_at) begin
            reset_fpga = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
            #1;
            check_reset_outputs();
            sb.delete();
            @(negedge clk_fpga);
            reset_fpga = 1'b1;
            return;
         end
         frame_start = (c == 0) || (idx == fs_at && !fs_done);
         if (frame_start && c > 0) fs_done = 1;
         pixel_valid = rnd_valid ? ($urandom % 4 != 0) : 1'b1;
         pixel_in    = 8'(img[idx]);
         #4;
         if (idx == 300) check("busy_active", busy, 1);
         if (pixel_valid && pixel_ready) begin
            e.x = idx % 24; e.y = idx / 24;
            e.sum = ref_ii(e.x, e.y); e.last = (idx == 575);
            sb.push_back(e);
            idx++;
         end
         c++;
      end
      d0 = done_cnt;
      @(negedge clk_fpga);
      pixel_valid = 1'b0; frame_start = 1'b0;
      check("frame_pixels_accepted", idx, 576);
      while (done_cnt == d0 && c2 < 200) begin
         @(negedge clk_fpga);
         c2++;
      end
      check("frame_done_seen", done_cnt - d0, 1);
      @(negedge clk_fpga);
      check("busy_idle", busy, 0);
      check("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_fpga);
      check_reset_outputs();
      reset_fpga = 1'b1;
      stall_en = 1; run_frame(0, 0, -1, -1); stall_en = 0;
      check("stall_happened", stall_done, 1);
      run_frame(1, 0, -1, -1);
      ready_mode = 1; run_frame(2, 1, 2*24 + 5, -1);
      run_frame(0, 1, -1, 7*24 + 12);
      ready_mode = 0; run_frame(0, 0, -1, -1);
      ready_mode = 1; run_frame(1, 1, -1, -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
